// File: rtl/als_spi_reader.sv
// SPI master reading ambient-light ADC frames from PmodALS-style sensors.
// All sensors share SCLK and SDO; each has its own chip select.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_start    single-shot request (sampled in IDLE only)
//   i_ch       channel for a single-shot request (ignored if >= N_CH)
//   i_auto     continuous round-robin scan enable (wins over i_start)
//   i_sdo      shared serial data from the selected sensor
//   o_sclk     SPI clock, registered, idle high
//   o_cs_n     per-sensor chip selects, active low, registered
//   o_data     last conversion result
//   o_ch       channel of o_data
//   o_valid    one-cycle pulse marking new o_data/o_ch
//   o_busy     high in every state except IDLE
module als_spi_reader #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned N_CH         = 2,
  parameter int unsigned FRAME_CLKS   = 16,
  parameter int unsigned LEAD_ZEROS   = 3,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned QUIET_CYCLES = 8,
  // May be overridden wider than needed so out-of-range channels are expressible.
  parameter int unsigned CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [CH_W-1:0]      i_ch,
  input  logic                 i_auto,
  input  logic                 i_sdo,
  output logic                 o_sclk,
  output logic [N_CH-1:0]      o_cs_n,
  output logic [DATA_BITS-1:0] o_data,
  output logic [CH_W-1:0]      o_ch,
  output logic                 o_valid,
  output logic                 o_busy
);

  localparam int unsigned HcW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BcW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam int unsigned QcW = (QUIET_CYCLES > 0) ? $clog2(QUIET_CYCLES + 1) : 1;
  // Leading padding simply falls off the top, so only the remaining bits are stored.
  localparam int unsigned ShW = FRAME_CLKS - LEAD_ZEROS;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StQuiet} state_e;

  state_e               state_q, state_d;
  logic [HcW-1:0]       hcnt_q, hcnt_d;
  logic [BcW-1:0]       bcnt_q, bcnt_d;
  logic [QcW-1:0]       qcnt_q, qcnt_d;
  logic                 sclk_q, sclk_d;
  logic [N_CH-1:0]      cs_n_q, cs_n_d;
  logic [ShW-1:0]       shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
  logic                 valid_q, valid_d;
  logic [CH_W-1:0]      ptr_q, ptr_d;
  logic                 auto_frame_q, auto_frame_d;

  logic            launch;
  logic [CH_W-1:0] launch_ch;
  logic            hc_last;

  always_comb begin
    launch    = i_auto || (i_start && (32'(i_ch) < N_CH));
    launch_ch = i_auto ? ptr_q : i_ch;
    hc_last   = (hcnt_q == HcW'(CLK_DIV - 1));
  end

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    bcnt_d       = bcnt_q;
    qcnt_d       = qcnt_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    shift_d      = shift_q;
    data_d       = data_q;
    ch_d         = ch_q;
    cur_ch_d     = cur_ch_q;
    valid_d      = 1'b0;
    ptr_d        = ptr_q;
    auto_frame_d = auto_frame_q;

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d      = StSetup;
          hcnt_d       = '0;
          cur_ch_d     = launch_ch;
          auto_frame_d = i_auto;
          for (int unsigned i = 0; i < N_CH; i++) begin
            cs_n_d[i] = (32'(launch_ch) != i);
          end
        end
      end

      StSetup: begin
        if (hc_last) begin
          hcnt_d  = '0;
          bcnt_d  = '0;
          sclk_d  = 1'b0;
          state_d = StShift;
        end else begin
          hcnt_d = hcnt_q + HcW'(1);
        end
      end

      StShift: begin
        if (hc_last) begin
          hcnt_d = '0;
          if (!sclk_q) begin
            // Rising edge: SDO has been stable for CLK_DIV cycles since the fall.
            sclk_d  = 1'b1;
            shift_d = {shift_q[ShW-2:0], i_sdo};
            if (bcnt_q == BcW'(FRAME_CLKS - 1)) begin
              state_d = StHold;
            end
          end else begin
            sclk_d = 1'b0;
            bcnt_d = bcnt_q + BcW'(1);
          end
        end else begin
          hcnt_d = hcnt_q + HcW'(1);
        end
      end

      StHold: begin
        if (hcnt_q == '0) begin
          valid_d = 1'b1;
          data_d  = shift_q[ShW-1 -: DATA_BITS];
          ch_d    = cur_ch_q;
        end
        if (hc_last) begin
          hcnt_d  = '0;
          qcnt_d  = '0;
          cs_n_d  = '1;
          state_d = StQuiet;
        end else begin
          hcnt_d = hcnt_q + HcW'(1);
        end
      end

      StQuiet: begin
        // Counter runs through QUIET_CYCLES inclusive before releasing to IDLE.
        if (qcnt_q == QcW'(QUIET_CYCLES)) begin
          state_d = StIdle;
          if (auto_frame_q) begin
            ptr_d = (32'(cur_ch_q) == N_CH - 1) ? '0 : cur_ch_q + CH_W'(1);
          end
        end else begin
          qcnt_d = qcnt_q + QcW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      hcnt_q       <= '0;
      bcnt_q       <= '0;
      qcnt_q       <= '0;
      sclk_q       <= 1'b1;
      cs_n_q       <= '1;
      shift_q      <= '0;
      data_q       <= '0;
      ch_q         <= '0;
      cur_ch_q     <= '0;
      valid_q      <= 1'b0;
      ptr_q        <= '0;
      auto_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      bcnt_q       <= bcnt_d;
      qcnt_q       <= qcnt_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      ch_q         <= ch_d;
      cur_ch_q     <= cur_ch_d;
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
      auto_frame_q <= auto_frame_d;
    end
  end

  assign o_sclk  = sclk_q;
  assign o_cs_n  = cs_n_q;
  assign o_data  = data_q;
  assign o_ch    = ch_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_als_spi_reader.sv
// Bench for als_spi_reader: two sensor models on a shared SDO line, a scoreboard
// of expected {ch, data} results popped on every o_valid, and per-scenario tasks.
module tb_als_spi_reader;

  localparam int unsigned CLK_DIV      = 2;
  localparam int unsigned N_CH         = 2;
  localparam int unsigned FRAME_CLKS   = 16;
  localparam int unsigned LEAD_ZEROS   = 3;
  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned QUIET_CYCLES = 8;
  localparam int unsigned CH_W         = 2;  // wide enough to express channel 2 and 3

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CH_W-1:0] tb_ch = '0;
  logic            auto_en = 1'b0;
  logic            sdo;
  logic            sclk;
  logic [1:0]      cs_n;
  logic [7:0]      odata;
  logic [CH_W-1:0] och;
  logic            valid;
  logic            busy;

  always #5 clk = ~clk;

  als_spi_reader #(
    .CLK_DIV      (CLK_DIV),
    .N_CH         (N_CH),
    .FRAME_CLKS   (FRAME_CLKS),
    .LEAD_ZEROS   (LEAD_ZEROS),
    .DATA_BITS    (DATA_BITS),
    .QUIET_CYCLES (QUIET_CYCLES),
    .CH_W         (CH_W)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_start   (start),
    .i_ch      (tb_ch),
    .i_auto    (auto_en),
    .i_sdo     (sdo),
    .o_sclk    (sclk),
    .o_cs_n    (cs_n),
    .o_data    (odata),
    .o_ch      (och),
    .o_valid   (valid),
    .o_busy    (busy)
  );

  // Sensor models: CS high holds them in reset; each SCLK fall drives the next bit.
  logic [7:0]  payload0 = 8'h00;
  logic [7:0]  payload1 = 8'h00;
  logic [15:0] frame0, frame1;
  logic [3:0]  s0_idx, s1_idx;
  logic        s0_bit, s1_bit;

  assign frame0 = {3'b000, payload0, 5'b00000};
  assign frame1 = {3'b000, payload1, 5'b00000};

  always @(negedge sclk or posedge cs_n[0]) begin
    if (cs_n[0]) begin
      s0_idx <= 4'd15;
      s0_bit <= 1'b0;
    end else begin
      s0_bit <= frame0[s0_idx];
      s0_idx <= s0_idx - 4'd1;
    end
  end

  always @(negedge sclk or posedge cs_n[1]) begin
    if (cs_n[1]) begin
      s1_idx <= 4'd15;
      s1_bit <= 1'b0;
    end else begin
      s1_bit <= frame1[s1_idx];
      s1_idx <= s1_idx - 4'd1;
    end
  end

  assign sdo = !cs_n[0] ? s0_bit : (!cs_n[1] ? s1_bit : 1'b0);

  // Scoreboard and counters.
  logic [CH_W+7:0] exp_q[$];
  logic [CH_W+7:0] mon_e;
  int n_checks = 0;
  int n_pass = 0;
  int valid_count = 0;
  int cs_viol = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid === 1'b1) begin
        valid_count++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_valid: got ch=%0d data=%h, required no o_valid", och, odata);
        end else begin
          mon_e = exp_q.pop_front();
          if ({och, odata} !== mon_e)
            $display("FAIL result: got ch=%0d data=%h, required ch=%0d data=%h",
                     och, odata, mon_e[CH_W+7:8], mon_e[7:0]);
          else n_pass++;
        end
      end
      if (!(cs_n === 2'b11 || cs_n === 2'b10 || cs_n === 2'b01)) cs_viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the request is sampled (cycle 1).
  task automatic fire(input logic [CH_W-1:0] c);
    tick();
    start = 1'b1;
    tb_ch = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valids(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (sclk !== 1'b1) $display("FAIL rst_sclk: got %b, required 1", sclk); else n_pass++;
    n_checks++; if (cs_n !== 2'b11) $display("FAIL rst_cs_n: got %b, required 11", cs_n); else n_pass++;
    n_checks++; if (odata !== 8'h00) $display("FAIL rst_data: got %h, required 00", odata); else n_pass++;
    n_checks++; if (och !== 2'd0) $display("FAIL rst_ch: got %0d, required 0", och); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [1:0] cs1;
    logic prev;
    int first_fall, rises, valid_cyc, cs_off, idle_cyc;
    payload0 = 8'hC3;
    exp_q.push_back({2'd0, 8'hC3});
    first_fall = -1; rises = 0; valid_cyc = -1; cs_off = -1; idle_cyc = -1;
    prev = 1'b1; cs1 = 2'bxx;
    fire(2'd0);
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (c == 1) cs1 = cs_n;
      if (sclk === 1'b0 && first_fall < 0) first_fall = c;
      if (prev === 1'b0 && sclk === 1'b1) rises++;
      prev = sclk;
      if (valid === 1'b1 && valid_cyc < 0) valid_cyc = c;
      if (c > 1 && cs_n === 2'b11 && cs_off < 0) cs_off = c;
      if (busy === 1'b0 && idle_cyc < 0) idle_cyc = c;
    end
    n_checks++; if (cs1 !== 2'b10) $display("FAIL single_cs_cycle1: got %b, required 10", cs1); else n_pass++;
    n_checks++; if (first_fall != 3) $display("FAIL single_first_fall: got %0d, required 3", first_fall); else n_pass++;
    n_checks++; if (rises != 16) $display("FAIL single_rises: got %0d, required 16", rises); else n_pass++;
    n_checks++; if (valid_cyc != 66) $display("FAIL single_valid_cycle: got %0d, required 66", valid_cyc); else n_pass++;
    n_checks++; if (cs_off != 67) $display("FAIL single_cs_release: got %0d, required 67", cs_off); else n_pass++;
    n_checks++; if (idle_cyc != 76) $display("FAIL single_idle_cycle: got %0d, required 76", idle_cyc); else n_pass++;
  endtask

  task automatic test_boundary();
    logic [7:0] pats [4];
    logic [1:0] c;
    bit ok;
    int vc0;
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'hFF; pats[3] = 8'h00;
    vc0 = valid_count;
    for (int i = 0; i < 4; i++) begin
      c = 2'(i % 2);
      if (c == 2'd0) payload0 = pats[i]; else payload1 = pats[i];
      exp_q.push_back({c, pats[i]});
      fire(c);
      wait_idle(ok);
      n_checks++; if (!ok) $display("FAIL boundary_idle_%0d: got busy, required idle", i); else n_pass++;
    end
    n_checks++;
    if (valid_count - vc0 != 4) $display("FAIL boundary_valids: got %0d, required 4", valid_count - vc0);
    else n_pass++;
  endtask

  task automatic test_illegal();
    bit saw_busy, saw_cs;
    int vc0;
    saw_busy = 1'b0; saw_cs = 1'b0; vc0 = valid_count;
    for (int c = 2; c <= 3; c++) begin
      fire(2'(c));
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (busy !== 1'b0) saw_busy = 1'b1;
        if (cs_n !== 2'b11) saw_cs = 1'b1;
      end
    end
    n_checks++; if (saw_busy) $display("FAIL illegal_busy: got 1, required 0"); else n_pass++;
    n_checks++; if (saw_cs) $display("FAIL illegal_cs: got activity, required 11"); else n_pass++;
    n_checks++;
    if (valid_count != vc0) $display("FAIL illegal_valid: got %0d, required 0", valid_count - vc0);
    else n_pass++;
  endtask

  task automatic test_start_during_shift();
    bit ok;
    int vc0;
    payload0 = 8'hA5;
    vc0 = valid_count;
    exp_q.push_back({2'd0, 8'hA5});
    fire(2'd0);
    repeat (20) tick();
    start = 1'b1;
    tb_ch = 2'd1;
    tick();
    start = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL shift_start_idle: got busy, required idle"); else n_pass++;
    repeat (10) tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL shift_start_requeue: got busy=%b, required 0", busy); else n_pass++;
    n_checks++;
    if (valid_count - vc0 != 1) $display("FAIL shift_start_valids: got %0d, required 1", valid_count - vc0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic prev;
    int rises, vc0;
    bit found, ok;
    payload0 = 8'h3C;
    vc0 = valid_count; rises = 0; prev = 1'b1; found = 1'b0;
    fire(2'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prev === 1'b0 && sclk === 1'b1) rises++;
      prev = sclk;
      if (rises == 7 && sclk === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (!found) $display("FAIL rstmid_reach_bit7: got %0d rises, required 7", rises); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (sclk !== 1'b1) $display("FAIL rstmid_sclk: got %b, required 1", sclk); else n_pass++;
    n_checks++; if (cs_n !== 2'b11) $display("FAIL rstmid_cs_n: got %b, required 11", cs_n); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %b, required 0", valid); else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (80) tick();
    n_checks++;
    if (valid_count != vc0) $display("FAIL rstmid_no_valid: got %0d, required 0", valid_count - vc0);
    else n_pass++;
    exp_q.push_back({2'd0, 8'h3C});
    fire(2'd0);
    wait_idle(ok);
    n_checks++;
    if (!ok || valid_count - vc0 != 1)
      $display("FAIL rstmid_fresh: got %0d valids, required 1", valid_count - vc0);
    else n_pass++;
  endtask

  task automatic test_auto();
    bit ok, saw_cs, saw_busy;
    int vc0;
    payload0 = 8'hC3;
    payload1 = 8'h5A;
    vc0 = valid_count;
    exp_q.push_back({2'd0, 8'hC3});
    exp_q.push_back({2'd1, 8'h5A});
    exp_q.push_back({2'd0, 8'hC3});
    exp_q.push_back({2'd1, 8'h5A});
    tick();
    auto_en = 1'b1;
    wait_valids(vc0 + 3, ok);
    n_checks++; if (!ok) $display("FAIL auto_three: got %0d valids, required 3", valid_count - vc0); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs_n === 2'b01) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) $display("FAIL auto_ch1_select: got cs_n=%b, required 01", cs_n); else n_pass++;
    auto_en = 1'b0;
    wait_valids(vc0 + 4, ok);
    n_checks++; if (!ok) $display("FAIL auto_drop_valid: got %0d valids, required 4", valid_count - vc0); else n_pass++;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL auto_drop_idle: got busy, required idle"); else n_pass++;
    saw_cs = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (cs_n !== 2'b11) saw_cs = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    n_checks++; if (saw_cs) $display("FAIL auto_drop_cs: got activity, required 11"); else n_pass++;
    n_checks++; if (saw_busy) $display("FAIL auto_drop_busy: got 1, required 0"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_illegal();
    test_start_during_shift();
    test_reset_mid();
    test_auto();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (cs_viol != 0) $display("FAIL cs_exclusive: got %0d bad cycles, required 0", cs_viol);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/als_spi_reader.md
Name: als_spi_reader

Overview:
- Synthesizable SPI master that reads ambient-light ADC frames from one or more PmodALS-style sensors sharing SCLK and a tri-stated SDO line, with one chip select per sensor.
- Generalises the single-device, fixed 8-bit frame of the current sensor interface with parametrised data width, frame length, zero-padding, SCLK divider and channel count.
- Adds single-shot and continuous round-robin scan modes.
- Sits between the board pins and the light-level processing logic.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period (>=1)
N_CH, 2, number of sensors / chip selects (1..8)
FRAME_CLKS, 16, SCLK cycles per frame
LEAD_ZEROS, 3, zero samples preceding the data MSB
DATA_BITS, 8, result width; LEAD_ZEROS+DATA_BITS <= FRAME_CLKS
QUIET_CYCLES, 8, minimum system clocks with all CS high between frames
CH_W, $clog2(N_CH) (min 1), channel index width

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_start  in  1  single-shot request, sampled in IDLE only
i_ch  in  CH_W  channel for single-shot request
i_auto  in  1  continuous round-robin scan enable
i_sdo  in  1  shared sensor serial data
o_sclk  out  1  SPI clock, registered, idle high
o_cs_n  out  N_CH  per-sensor chip selects, active low, registered
o_data  out  DATA_BITS  last conversion result
o_ch  out  CH_W  channel of o_data
o_valid  out  1  one-cycle pulse, new o_data/o_ch
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): o_sclk=1, o_cs_n=all 1, o_data=0, o_ch=0, o_valid=0, o_busy=0, state IDLE, scan pointer=0, counters 0. Reset mid-frame aborts the frame; no o_valid.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> QUIET -> IDLE.
- IDLE:
  - If i_auto=1, start a frame on the scan pointer channel.
  - Else if i_start=1 and i_ch<N_CH, start a frame on i_ch.
  - Requests with i_ch>=N_CH are ignored.
  - i_auto has priority over simultaneous i_start.
  - i_start outside IDLE is ignored, not queued.
- Frame start (cycle 0 = IDLE cycle sampling the request):
  - Cycle 1: o_cs_n[ch]=0, other CS stay 1; enter SETUP.
  - SETUP lasts CLK_DIV cycles with o_sclk=1.
- SHIFT: FRAME_CLKS SCLK periods.
  - Each period: o_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - First fall at cycle 1+CLK_DIV.
  - i_sdo is shifted MSB-first into a FRAME_CLKS-bit register on the clock edge where o_sclk transitions 0->1, i.e. CLK_DIV cycles after the sensor updated SDO on the fall.
  - Last rise occurs at cycle 1+2*FRAME_CLKS*CLK_DIV.
- Result extraction, on the cycle after the last rise:
  - o_data = shift[FRAME_CLKS-1-LEAD_ZEROS -: DATA_BITS].
  - o_ch = channel; o_valid=1 for that single cycle.
  - Leading and trailing padding bits are discarded unchecked.
  - o_data/o_ch hold until the next o_valid.
- HOLD: o_sclk=1, CS still low for CLK_DIV cycles after the last rise, then o_cs_n=all 1; enter QUIET.
- QUIET: QUIET_CYCLES cycles, all CS high. Then:
  - Auto mode: scan pointer = (ch+1) wrapping N_CH-1 -> 0.
  - Return to IDLE; o_busy drops on the IDLE cycle.
  - Back-to-back auto frames therefore have one IDLE cycle between them.
- i_auto deasserted mid-frame: the current frame completes with o_valid, then the block stays in IDLE.
- The scan pointer is not reset by single-shot frames. Single shots do not advance the pointer.
- Counters: the half-period counter counts 0..CLK_DIV-1; the bit counter counts 0..FRAME_CLKS-1. No other wrap conditions exist.

Test Plan:
- Bench configuration: CLK_DIV=2, N_CH=2, FRAME_CLKS=16, LEAD_ZEROS=3, DATA_BITS=8, QUIET_CYCLES=8. Sensor models use an async-reset flop model driving SDO on SCLK fall.
- Single shot: i_start=1, i_ch=0, sensor 0 payload 8'hC3 -> o_cs_n=2'b10 at cycle 1; first o_sclk fall at cycle 3; 16 rises; o_valid at cycle 66 with o_data=8'hC3, o_ch=0; o_cs_n=2'b11 at cycle 67; o_busy low at cycle 76.
- Auto scan: i_auto=1, payloads 8'hC3 (ch0) and 8'h5A (ch1) -> valids in order ch0=C3, ch1=5A, ch0=C3; never two CS low at once.
- Boundary data: payloads 8'h00 and 8'hFF -> exact results, no padding bit leakage.
- Illegal/ignored requests: i_ch=2 with N_CH=2 -> o_busy stays 0, no CS activity; i_start pulsed during SHIFT -> exactly one o_valid.
- Reset mid-frame: i_reset_n=0 during SHIFT bit 7 -> o_sclk=1 and o_cs_n=2'b11 in the same cycle, no o_valid; after release, a fresh start returns the correct payload.
- i_auto dropped during the ch1 frame -> that frame delivers o_valid, then IDLE with o_busy=0 and no further CS assertion.
